// File: rtl/mem_bus_master.sv
// CPU-side initiator for the multiplexed AddrData memory bus: one valid/ready command
// becomes an address cycle followed by a BURST_LEN-word write or read burst.
module mem_bus_master #(
  parameter int DATA_W     = 16,
  parameter int BURST_LEN  = 4,
  parameter int RD_LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        resetL,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_rw,
  input  logic [DATA_W-1:0]           cmd_addr,
  input  logic [BURST_LEN*DATA_W-1:0] cmd_wdata,
  output logic                        rsp_done,
  output logic [BURST_LEN*DATA_W-1:0] rsp_rdata,
  inout  wire  [DATA_W-1:0]           AddrData,
  output logic                        AddrValid,
  output logic                        rw
);

  localparam int CNT_W  = $clog2(BURST_LEN) + 1;
  localparam int WAIT_W = $clog2(RD_LATENCY) + 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]  BEAT_ONE  = CNT_W'(1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(RD_LATENCY - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  generate
    if (RD_LATENCY < 2) begin : g_rd_latency_check
      $error("mem_bus_master: RD_LATENCY must be >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_RWAIT = 3'd3,
    S_RDATA = 3'd4
  } state_t;

  state_t                        state_r, state_s;
  logic [CNT_W-1:0]              beat_r, beat_s, next_beat_s;
  logic [WAIT_W-1:0]             wait_r, wait_s;
  logic                          is_read_r;
  logic [BURST_LEN*DATA_W-1:0]   wdata_r;
  logic [BURST_LEN*DATA_W-1:0]   rbuf_r;
  logic [BURST_LEN*DATA_W-1:0]   rdata_full_s;
  logic [BURST_LEN*DATA_W-1:0]   rsp_rdata_r, rsp_rdata_s;
  logic [DATA_W-1:0]             bus_out_r, bus_out_s;
  logic                          drive_en_r, drive_en_s;
  logic                          addr_valid_r, addr_valid_s;
  logic                          rw_r, rw_s;
  logic                          cmd_ready_r, cmd_ready_s;
  logic                          rsp_done_r, rsp_done_s;
  logic                          accept_s;

  // Next state plus the next value of every registered bus/response output.
  always_comb begin
    state_s      = state_r;
    beat_s       = beat_r;
    wait_s       = wait_r;
    next_beat_s  = beat_r + BEAT_ONE;
    bus_out_s    = {DATA_W{1'b0}};
    rw_s         = 1'b0;
    rsp_done_s   = 1'b0;
    rsp_rdata_s  = rsp_rdata_r;
    accept_s     = 1'b0;
    rdata_full_s = rbuf_r;
    // Last read word goes straight into the response, so it is valid in the done cycle.
    rdata_full_s[(BURST_LEN-1)*DATA_W +: DATA_W] = AddrData;
    case (state_r)
      S_IDLE: begin
        if (cmd_valid) begin
          accept_s  = 1'b1;
          state_s   = S_ADDR;
          bus_out_s = cmd_addr;
          rw_s      = cmd_rw;
        end else begin
          state_s   = S_IDLE;
        end
      end
      S_ADDR: begin
        if (is_read_r) begin
          state_s = S_RWAIT;
          wait_s  = WAIT_ONE;
        end else begin
          state_s   = S_WDATA;
          beat_s    = {CNT_W{1'b0}};
          bus_out_s = wdata_r[DATA_W-1:0];
        end
      end
      S_WDATA: begin
        if (beat_r == LAST_BEAT) begin
          state_s    = S_IDLE;
          beat_s     = {CNT_W{1'b0}};
          rsp_done_s = 1'b1;
        end else begin
          beat_s    = next_beat_s;
          bus_out_s = wdata_r[next_beat_s*DATA_W +: DATA_W];
        end
      end
      S_RWAIT: begin
        if (wait_r == LAST_WAIT) begin
          state_s = S_RDATA;
          beat_s  = {CNT_W{1'b0}};
        end else begin
          wait_s  = wait_r + WAIT_ONE;
        end
      end
      S_RDATA: begin
        if (beat_r == LAST_BEAT) begin
          state_s     = S_IDLE;
          beat_s      = {CNT_W{1'b0}};
          rsp_done_s  = 1'b1;
          rsp_rdata_s = rdata_full_s;
        end else begin
          beat_s = next_beat_s;
        end
      end
      default: begin
        state_s = S_IDLE;
        beat_s  = {CNT_W{1'b0}};
        wait_s  = {WAIT_W{1'b0}};
      end
    endcase
    addr_valid_s = (state_s == S_ADDR);
    drive_en_s   = (state_s == S_ADDR) || (state_s == S_WDATA);
    cmd_ready_s  = (state_s == S_IDLE);
  end

  // State, captured command and all outputs; reset releases the bus immediately.
  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      state_r      <= S_IDLE;
      beat_r       <= {CNT_W{1'b0}};
      wait_r       <= {WAIT_W{1'b0}};
      is_read_r    <= 1'b0;
      wdata_r      <= {(BURST_LEN*DATA_W){1'b0}};
      rbuf_r       <= {(BURST_LEN*DATA_W){1'b0}};
      rsp_rdata_r  <= {(BURST_LEN*DATA_W){1'b0}};
      bus_out_r    <= {DATA_W{1'b0}};
      drive_en_r   <= 1'b0;
      addr_valid_r <= 1'b0;
      rw_r         <= 1'b0;
      cmd_ready_r  <= 1'b1;
      rsp_done_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      beat_r       <= beat_s;
      wait_r       <= wait_s;
      rsp_rdata_r  <= rsp_rdata_s;
      bus_out_r    <= bus_out_s;
      drive_en_r   <= drive_en_s;
      addr_valid_r <= addr_valid_s;
      rw_r         <= rw_s;
      cmd_ready_r  <= cmd_ready_s;
      rsp_done_r   <= rsp_done_s;
      if (accept_s) begin
        is_read_r <= cmd_rw;
        wdata_r   <= cmd_wdata;
      end
      if (state_r == S_RDATA) begin
        rbuf_r[beat_r*DATA_W +: DATA_W] <= AddrData;
      end
    end
  end

  assign AddrData  = drive_en_r ? bus_out_r : {DATA_W{1'bz}};
  assign AddrValid = addr_valid_r;
  assign rw        = rw_r;
  assign cmd_ready = cmd_ready_r;
  assign rsp_done  = rsp_done_r;
  assign rsp_rdata = rsp_rdata_r;

endmodule
